constant_multiplier: RTL and testbench
======================================

# constant_multiplier

Pipelined log-domain scaler for the output buffer path. It takes an unsigned W-bit word and produces a fixed-point log2 approximation (Mitchell style): the leading-one position is the integer part, and the normalized bits below the leading one are the fraction. That value is then multiplied by the constant 1.0111b (1.4375). The block sits after the output buffer and before log-domain arithmetic or quantization logic.

## Interface
Parameters:
- W, 32: input/output data width (`OUTPUT_BUF_DATASIZE`).
- FRAC, 16: fractional bits of the log value and of `out` (Q(W-FRAC).FRAC).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- in  in  W  unsigned operand.
- leading_one_pos  out  W  stage-1 register: index p of the most significant 1 of `in`, zero-extended.
- one_hot  out  W  stage-1 register: 1<<p; all-zero when `in`==0.
- out  out  W  scaled log value, Q(W-FRAC).FRAC, unsigned.

## Operation
- Stage 1 (leading-one detect):
  - p = highest set bit index of `in`.
  - Register p, one_hot, and a copy of `in`.
- Stage 2 (normalize, "shift"):
  - n = in_r << (W-1-p), so the leading one lands at bit W-1.
  - frac = n[W-2 : W-1-FRAC].
  - log = (p << FRAC) | frac.
  - Register log.
  - When p < FRAC, the missing low fraction bits are zero-filled.
  - Bits beyond FRAC below the leading one are truncated, not rounded.
- Constant multiply (combinational from the stage-2 register):
  - out = log + (log>>2) + (log>>3) + (log>>4).
  - Each shifted term is truncated independently. No rounding.
- Width rule: W-FRAC must hold floor(1.4375·(W-1)) + 1. This is 6 bits for W=32, so no overflow can occur. Check it with an elaboration-time assertion.
- Zero input: p=0, one_hot=0, log=0, out=0. There is no separate zero flag.
- `in`=1 also yields log=0. Downstream consumers distinguish it from zero via one_hot.

## Timing
- Fully pipelined, no handshake. A new operand is accepted every cycle.
- leading_one_pos and one_hot are valid 1 cycle after `in` is sampled.
- out is valid 2 cycles after `in` is sampled.
- Reset: at the first rising edge with rst=1, all registers clear. From that edge leading_one_pos=0, one_hot=0, out=0.
- Reset mid-stream discards all in-flight operands.
- Operands presented on the first edge after rst deasserts emerge normally 2 cycles later.
- Back-to-back different operands produce back-to-back results in order, with no bubbles.

## Structure
- Shared package holds:
  - W and FRAC defaults, taken from `OUTPUT_BUF_DATASIZE`.
  - The constant coefficient as its shift-term list {0,2,3,4}, so the constant can be retuned in one place.
- One natural sub-module: `leading_one_detector`, a parameterized priority encoder producing p and one_hot. It is purely combinational; the top level owns the registers.
- The normalizing barrel shift and the shift-add constant multiply are written inline in the top level.

## Test plan
- in=0x10106808 (p=28) -> after 1 cycle, leading_one_pos=28 and one_hot=0x10000000. After 2 cycles, out=0x00284177 (log 0x001C0106).
- in=0x80000000 -> leading_one_pos=31 and one_hot=0x80000000. out=0x002C9000.
- in=3 -> log=0x00018000 and out=0x00022800. in=1 -> out=0 with one_hot=0x00000001.
- in=0 -> one_hot=0 and out=0.
- Stream 0x80000000, 3, 0x10106808 on consecutive cycles -> outputs 0x2C9000, 0x22800, 0x284177 on consecutive cycles, starting 2 cycles after the first input.
- Assert rst for 1 cycle while two operands are in flight -> all outputs 0 from that edge. The next operand applied after release produces the correct result 2 cycles later.

Source files
------------

// File: rtl/constant_multiplier_pkg.sv
// Shared parameters for the log-domain constant scaler.
// Holds default widths and the coefficient as a list of shift terms.
package constant_multiplier_pkg;

    localparam int OUTPUT_BUF_DATASIZE = 32;
    localparam int W_DEF = OUTPUT_BUF_DATASIZE;
    localparam int FRAC_DEF = 16;

    // Coefficient 1.0111b = sum of (x >> s) over these shifts.
    localparam int COEF_TERMS = 4;
    localparam int COEF_SHIFTS [COEF_TERMS] = '{0, 2, 3, 4};

    // Coefficient scaled by 16, used for the headroom check.
    function automatic int coef_x16();
        int acc;
        acc = 0;
        for (int i = 0; i < COEF_TERMS; i++) begin
            acc = acc + (16 >> COEF_SHIFTS[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/constant_multiplier_if.sv
// Data bundle of the constant multiplier.
// Ports: in (operand), leading_one_pos, one_hot, out (results).
interface constant_multiplier_if
    import constant_multiplier_pkg::*;
#(
    parameter int W = W_DEF
);
    logic [W-1:0] in;
    logic [W-1:0] leading_one_pos;
    logic [W-1:0] one_hot;
    logic [W-1:0] out;

    modport master (
        output in,
        input  leading_one_pos,
        input  one_hot,
        input  out
    );

    modport slave (
        input  in,
        output leading_one_pos,
        output one_hot,
        output out
    );
endinterface

// File: rtl/leading_one_detector.sv
// Combinational priority encoder for the most significant set bit.
// Ports: din in, pos = index (zero-extended), one_hot = 1<<pos or 0.
module leading_one_detector #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] pos,
    output logic [W-1:0] one_hot
);

    // Ascending scan: the highest set bit is the last one to win.
    always_comb begin
        pos = '0;
        one_hot = '0;
        for (int i = 0; i < W; i++) begin
            if (din[i]) begin
                pos = W'(i);
                one_hot = '0;
                one_hot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/constant_multiplier.sv
// Two-stage Mitchell log2 of an unsigned word, scaled by 1.4375.
// Ports: clk, rst (sync, active-high), bus (slave: in -> lop/one_hot/out).
module constant_multiplier
    import constant_multiplier_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic clk,
    input  logic rst,
    constant_multiplier_if.slave bus
);

    // Integer part of the scaled log must fit in W-FRAC bits.
    if (!((coef_x16() * (W - 1)) / 16 + 1 < (1 << (W - FRAC)))) begin : g_width_chk
        $error("constant_multiplier: W-FRAC too small for scaled log");
    end

    logic [W-1:0] lod_pos;
    logic [W-1:0] lod_oh;

    logic [W-1:0] p_d, p_q;
    logic [W-1:0] one_hot_d, one_hot_q;
    logic [W-1:0] in_d, in_q;
    logic [W-1:0] log_d, log_q;
    logic [W-1:0] norm;
    logic [W-1:0] frac;
    logic [W-1:0] out_w;

    leading_one_detector #(
        .W (W)
    ) u_lod (
        .din     (bus.in),
        .pos     (lod_pos),
        .one_hot (lod_oh)
    );

    always_comb begin
        p_d = lod_pos;
        one_hot_d = lod_oh;
        in_d = bus.in;
        // Leading one lands at W-1; dropping it leaves the fraction on top.
        norm = in_q << (W'(W - 1) - p_q);
        frac = (norm << 1) >> (W - FRAC);
        log_d = (p_q << FRAC) | frac;
    end

    // Each shifted term truncates on its own.
    always_comb begin
        out_w = '0;
        for (int i = 0; i < COEF_TERMS; i++) begin
            out_w = out_w + (log_q >> COEF_SHIFTS[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            one_hot_q <= '0;
            in_q <= '0;
            log_q <= '0;
        end else begin
            p_q <= p_d;
            one_hot_q <= one_hot_d;
            in_q <= in_d;
            log_q <= log_d;
        end
    end

    assign bus.leading_one_pos = p_q;
    assign bus.one_hot = one_hot_q;
    assign bus.out = out_w;

endmodule

// File: tb/tb_constant_multiplier.sv
// Scoreboard bench for constant_multiplier.
// Stage-2 expectations queue up as operands are driven.
module tb_constant_multiplier;

    logic clk;
    logic rst;
    int checks;
    int errors;
    logic [31:0] q2 [$];

    constant_multiplier_if #(.W(32)) bus ();

    constant_multiplier #(
        .W    (32),
        .FRAC (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_pos(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] m_oh(input logic [31:0] v);
        if (v == 0) return 32'h0;
        return 32'h1 << m_pos(v);
    endfunction

    function automatic logic [31:0] m_out(input logic [31:0] v);
        int p;
        logic [31:0] f;
        logic [31:0] lg;
        p = m_pos(v);
        if (p >= 16) f = (v >> (p - 16)) & 32'hFFFF;
        else f = (v << (16 - p)) & 32'hFFFF;
        lg = (32'(p) << 16) | f;
        return lg + (lg >> 2) + (lg >> 3) + (lg >> 4);
    endfunction

    // Drive one operand across an edge; returns the out expected now.
    task automatic step(input logic [31:0] v, input logic [31:0] ov,
                        output logic [31:0] oe);
        bus.in = v;
        @(posedge clk);
        #1;
        q2.push_back(ov);
        if (q2.size() > 1) oe = q2.pop_front();
        else oe = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        checks++;
        if (bus.leading_one_pos !== 32'h0 || bus.one_hot !== 32'h0 ||
            bus.out !== 32'h0) begin
            errors++;
            $display("FAIL reset: lop=%h oh=%h out=%h want 0", bus.leading_one_pos,
                     bus.one_hot, bus.out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q2.delete();
        q2.push_back(32'h0);
    endtask

    task automatic test_vectors();
        logic [31:0] ti [5] = '{32'h1010_6808, 32'h8000_0000, 32'h3, 32'h1, 32'h0};
        logic [31:0] tp [5] = '{32'd28, 32'd31, 32'd1, 32'd0, 32'd0};
        logic [31:0] th [5] = '{32'h1000_0000, 32'h8000_0000, 32'h2, 32'h1, 32'h0};
        logic [31:0] tq [5] = '{32'h0028_4177, 32'h002C_9000, 32'h0002_2800, 32'h0, 32'h0};
        logic [31:0] oe;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) step(ti[i], tq[i], oe);
            else step(32'h0, 32'h0, oe);
            if (i < 5) begin
                checks++;
                if (bus.leading_one_pos !== tp[i]) begin
                    errors++;
                    $display("FAIL vec_lop[%0d]: got %0d want %0d", i,
                             bus.leading_one_pos, tp[i]);
                end
                checks++;
                if (bus.one_hot !== th[i]) begin
                    errors++;
                    $display("FAIL vec_oh[%0d]: got %h want %h", i, bus.one_hot, th[i]);
                end
            end
            checks++;
            if (bus.out !== oe) begin
                errors++;
                $display("FAIL vec_out[%0d]: got %h want %h", i, bus.out, oe);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sv [3] = '{32'h8000_0000, 32'h3, 32'h1010_6808};
        logic [31:0] sq [3] = '{32'h002C_9000, 32'h0002_2800, 32'h0028_4177};
        logic [31:0] oe;
        logic [31:0] v;
        for (int i = 0; i < 28; i++) begin
            if (i < 3) v = sv[i];
            else v = $urandom() >> $urandom_range(31, 0);
            step(v, (i < 3) ? sq[i] : m_out(v), oe);
            checks++;
            if (bus.leading_one_pos !== 32'(m_pos(v)) || bus.one_hot !== m_oh(v)) begin
                errors++;
                $display("FAIL b2b_s1[%0d]: in=%h lop=%0d oh=%h want %0d %h", i, v,
                         bus.leading_one_pos, bus.one_hot, m_pos(v), m_oh(v));
            end
            checks++;
            if (bus.out !== oe) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got %h want %h", i, bus.out, oe);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] oe;
        step(32'h8000_0000, 32'h002C_9000, oe);
        step(32'h1010_6808, 32'h0028_4177, oe);
        rst = 1'b1;
        bus.in = 32'h3;
        @(posedge clk);
        #1;
        checks++;
        if (bus.leading_one_pos !== 32'h0 || bus.one_hot !== 32'h0 ||
            bus.out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: lop=%h oh=%h out=%h want 0", bus.leading_one_pos,
                     bus.one_hot, bus.out);
        end
        rst = 1'b0;
        q2.delete();
        q2.push_back(32'h0);
        step(32'h3, 32'h0002_2800, oe);
        checks++;
        if (bus.out !== 32'h0) begin
            errors++;
            $display("FAIL mid_flush: got %h want 0", bus.out);
        end
        step(32'h0, 32'h0, oe);
        checks++;
        if (bus.out !== 32'h0002_2800 || oe !== 32'h0002_2800) begin
            errors++;
            $display("FAIL mid_recover: got %h want %h", bus.out, 32'h0002_2800);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in = 32'h0;
        #2;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
